bus_master_ctrl: RTL
====================

Name: bus_master_ctrl

Overview:
- Master-side transaction sequencer for the serial shared bus.
- Accepts one parallel write command (slave select, memory address, write data) from local logic.
- Requests the bus from the arbiter, shifts the 2-bit slave select, then shifts address and data bits under the slave ready handshake.
- Reports done or error. One instance sits between each master core and its arbiter master port.

Parameters:
ADDR_W, 12, memory address bits shifted to the slave
DATA_W, 8, write data bits shifted to the slave
TIMEOUT, 16, max consecutive stall cycles and max arbitration retries before error (>=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset; reset=0 clears all state
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_sel  in  2  target slave: 0=S1, 1=S2, 2=S3, 3=illegal
cmd_addr  in  ADDR_W  target memory address
cmd_data  in  DATA_W  write data
bus_request  out  1  to arbiter request
bus_address_valid  out  1  to arbiter address_valid
bus_address  out  1  serial select/address line
bus_data  out  1  serial data line
bus_valid  out  1  bit-valid to slave via arbiter
bus_ready  in  1  slave ready routed back by arbiter
bus_available  in  1  arbiter available flag for this master
busy  out  1  transaction in progress (state != IDLE)
done  out  1  one-cycle pulse, transfer completed
err  out  1  one-cycle pulse, transfer aborted

Behaviour:
- Reset (async, reset=0):
  - State IDLE; all outputs 0 except cmd_ready=1.
  - Counters cleared.
  - A reset asserted mid-transfer drops bus_request immediately and produces no done/err pulse.
- Registered Moore FSM. All outputs decode from state and registers; no combinational input-to-output paths.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch sel/addr/data into shadow registers and clear retry_cnt.
  - If cmd_sel==3, go to ERROR; otherwise go to REQ.
- REQ:
  - bus_request=1, bus_address_valid=1, bus_address=0.
  - Go to SEL1.
- SEL1:
  - bus_request=1, bus_address=sel[1].
  - If bus_available==0 (arbitration lost):
    - retry_cnt++.
    - If retry_cnt reaches TIMEOUT-1, go to ERROR; otherwise return to REQ.
  - Otherwise go to SEL0.
- SEL0:
  - bus_request=1, bus_address=sel[0].
  - Go to CONN.
- CONN:
  - bus_request=1, all else 0 (arbiter connect cycle).
  - Go to ADDR with bit_cnt=ADDR_W-1 and stall_cnt=0.
- ADDR:
  - bus_request=1, bus_valid=1, bus_address=addr[bit_cnt] (MSB first).
  - Bit is consumed on a cycle with bus_ready=1:
    - bit_cnt--, stall_cnt=0.
    - After bit 0, go to DATA with bit_cnt=DATA_W-1.
- DATA:
  - bus_request=1, bus_valid=1, bus_data=data[bit_cnt] (MSB first), bus_address=0.
  - Same consume rule as ADDR. After bit 0, go to DONE.
- Stall (ADDR/DATA with bus_ready=0):
  - Hold current bit and stall_cnt++.
  - When stall_cnt reaches TIMEOUT, go to ERROR.
- DONE: done=1, bus_request=0, one cycle, then IDLE.
- ERROR: err=1, bus_request=0, one cycle, then IDLE.
- bus_address_valid is asserted only in REQ, so the arbiter never re-arbitrates mid-transfer.
- cmd_ready=0 in every state except IDLE. Commands offered while busy are ignored; they are not queued.
- Latency, no contention, bus_ready held 1: command accept to done pulse = 4 + ADDR_W + DATA_W + 1 cycles.
- Counters sized ceil(log2(max(ADDR_W, DATA_W, TIMEOUT)+1)). No wrap: the terminal compare precedes the increment.

Test Plan:
- Basic write: sel=1, addr=12'hA5C, data=8'h3C, bus_available=1, bus_ready=1.
  - Bits on bus_address: REQ, then 0,1.
  - Then A5C MSB first, then 00111100 on bus_data.
  - done pulses exactly 25 cycles after accept; err=0.
- Illegal select: sel=3.
  - err pulses the next cycle.
  - bus_request never rises; cmd_ready returns to 1 after 2 cycles.
- Stall: drop bus_ready for 5 cycles mid-address at bit 6.
  - bit 6 is held all 5 cycles, then the transfer continues.
  - done is delayed by exactly 5 cycles.
- Timeout: bus_ready=0 for 16 cycles in DATA.
  - err pulses and bus_request falls.
  - done is never asserted; the next command is accepted normally.
- Lost arbitration: bus_available=0 in SEL1 for 3 attempts, then 1.
  - FSM cycles REQ/SEL1 three times, then completes with done.
  - With bus_available held 0 throughout, err fires after TIMEOUT-1 attempts.
- Async reset: pull reset low during DATA.
  - All outputs clear immediately, without waiting for a clk edge; cmd_ready=1.
  - No done/err pulse.
  - A fresh command after release completes correctly.

Source files
------------

// File: rtl/bus_master_ctrl.sv
// Master-side sequencer for the serial shared bus: takes one parallel write command,
// wins the arbiter, shifts the slave select, then shifts address and data under slave handshake.
module bus_master_ctrl #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_sel,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              bus_request,
    output logic              bus_address_valid,
    output logic              bus_address,
    output logic              bus_data,
    output logic              bus_valid,
    input  logic              bus_ready,
    input  logic              bus_available,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int MAX_AD = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int MAX_N  = (MAX_AD > TIMEOUT) ? MAX_AD : TIMEOUT;
    localparam int CNT_W  = $clog2(MAX_N + 1);
    localparam int AIDX_W = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
    localparam int DIDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] ADDR_FIRST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_FIRST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(TIMEOUT - 2);

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQ,
        S_SEL1,
        S_SEL0,
        S_CONN,
        S_ADDR,
        S_DATA,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   retry_cnt_q, retry_cnt_d;

    logic addr_bit;
    logic data_bit;

    assign addr_bit = addr_q[bit_cnt_q[AIDX_W-1:0]];
    assign data_bit = data_q[bit_cnt_q[DIDX_W-1:0]];

    // NOTE: state and shadow registers are all cleared by reset so that an aborted
    // transfer leaves nothing behind; the shadow copies are small enough to afford it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            bit_cnt_q   <= '0;
            stall_cnt_q <= '0;
            retry_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from the
            // same pre-edge values, independent of statement order.
            state_q     <= state_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            bit_cnt_q   <= bit_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            retry_cnt_q <= retry_cnt_d;
        end
    end

    // Next-state and counter update.
    always_comb begin
        // NOTE: every variable gets a hold default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        data_d      = data_q;
        bit_cnt_d   = bit_cnt_q;
        stall_cnt_d = stall_cnt_q;
        retry_cnt_d = retry_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    sel_d       = cmd_sel;
                    addr_d      = cmd_addr;
                    data_d      = cmd_data;
                    retry_cnt_d = '0;
                    state_d     = (cmd_sel == 2'd3) ? S_ERROR : S_REQ;
                end
            end

            S_REQ: state_d = S_SEL1;

            S_SEL1: begin
                if (!bus_available) begin
                    // Terminal compare before the increment keeps the counter from wrapping.
                    if (retry_cnt_q == RETRY_LAST) begin
                        state_d = S_ERROR;
                    end else begin
                        retry_cnt_d = retry_cnt_q + 1'b1;
                        state_d     = S_REQ;
                    end
                end else begin
                    state_d = S_SEL0;
                end
            end

            S_SEL0: state_d = S_CONN;

            S_CONN: begin
                bit_cnt_d   = ADDR_FIRST;
                stall_cnt_d = '0;
                state_d     = S_ADDR;
            end

            S_ADDR, S_DATA: begin
                if (bus_ready) begin
                    stall_cnt_d = '0;
                    if (bit_cnt_q == '0) begin
                        if (state_q == S_ADDR) begin
                            bit_cnt_d = DATA_FIRST;
                            state_d   = S_DATA;
                        end else begin
                            state_d   = S_DONE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q - 1'b1;
                    end
                end else if (stall_cnt_q == STALL_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
            end

            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode: only state and registered fields, never raw inputs.
    always_comb begin
        cmd_ready         = 1'b0;
        bus_request       = 1'b0;
        bus_address_valid = 1'b0;
        bus_address       = 1'b0;
        bus_data          = 1'b0;
        bus_valid         = 1'b0;
        done              = 1'b0;
        err               = 1'b0;
        busy              = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: cmd_ready = 1'b1;
            S_REQ: begin
                bus_request       = 1'b1;
                bus_address_valid = 1'b1;
            end
            S_SEL1: begin
                bus_request = 1'b1;
                bus_address = sel_q[1];
            end
            S_SEL0: begin
                bus_request = 1'b1;
                bus_address = sel_q[0];
            end
            S_CONN: bus_request = 1'b1;
            S_ADDR: begin
                bus_request = 1'b1;
                bus_valid   = 1'b1;
                bus_address = addr_bit;
            end
            S_DATA: begin
                bus_request = 1'b1;
                bus_valid   = 1'b1;
                bus_data    = data_bit;
            end
            S_DONE:  done = 1'b1;
            S_ERROR: err  = 1'b1;
            default: ;
        endcase
    end

endmodule
